spin_encoder: RTL and testbench
===============================

SPIN_ENCODER -- requirements
Module: spin_encoder

Interface
REQ-001 Parameter OUTPUTS, default 8, number of encoded nodes; legal range 2..256.
REQ-002 Parameter SAT, default 1, 1 = saturating accumulation, 0 = wrap-around accumulation.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  term offered this cycle.
REQ-006 in_ready  output  1  term accepted when in_valid && in_ready.
REQ-007 in_data  input  32  signed weighted term (two's complement).
REQ-008 in_last  input  1  marks final term of current node.
REQ-009 node_idx  input  IW=$clog2(OUTPUTS)  target node; sampled only with the first term of a node.
REQ-010 clr  input  1  zero all node states; honoured only in IDLE.
REQ-011 z_out  output  OUTPUTS  per-node "positive" flag.
REQ-012 o_out  output  OUTPUTS  per-node "negative" flag.
REQ-013 done  output  1  one-cycle pulse when a node update commits.
REQ-014 err  output  1  sticky; set on out-of-range node_idx; cleared by rst or clr.

Function
REQ-015 Encoding per node i: (z,o)=(1,0) means +1, (0,1) means -1, (0,0) means 0; (1,1) SHALL never be produced.
REQ-016 FSM states: IDLE, ACCUM, ENCODE.
REQ-017 IDLE: in_ready=1; on an accepted term, latch node_idx, acc=in_data, then go to ENCODE if in_last, else go to ACCUM.
REQ-018 ACCUM: in_ready=1; each accepted term adds to acc; an accepted term with in_last goes to ENCODE.
REQ-019 ENCODE: in_ready=0; one cycle; commit the result, pulse done, return to IDLE.
REQ-020 Accumulator width: 34-bit internal sum.
REQ-021 SAT=1: the result SHALL clamp to [-2^31, 2^31-1] after every add.
REQ-022 SAT=0: the result SHALL truncate to 32 bits after every add.
REQ-023 Commit rule: acc>0 yields (1,0); acc<0 yields (0,1); acc==0 leaves the node's previous (z,o) unchanged.
REQ-024 Latency: done asserts exactly one cycle after the in_last handshake; z_out/o_out update on the same edge done rises.
REQ-025 Back-to-back: a new node's first term is accepted on the cycle after ENCODE; throughput is N+1 cycles for N terms.
REQ-026 in_valid=0 in ACCUM holds state indefinitely; no timeout.
REQ-027 node_idx >= OUTPUTS: ENCODE commits nothing, still pulses done, and sets err.
REQ-028 clr while not IDLE SHALL be ignored.
REQ-029 clr coincident with an accepted term in IDLE: clear first, then the term starts a node normally.
REQ-030 Only the addressed node changes on a commit; all other bits hold.

Reset
REQ-031 rst SHALL force: state=IDLE, acc=0, z_out=0, o_out=0, done=0, err=0; in_ready=1 on the first cycle after reset.
REQ-032 rst mid-ACCUM or mid-ENCODE SHALL abandon the partial sum with no commit and no done pulse.
REQ-033 rst has priority over clr and over any handshake.

Structure
REQ-034 A shared package SHALL hold: the FSM state enum, the 2-bit spin-code constants (POS=2'b10, NEG=2'b01, ZERO=2'b00), and the 32-bit term-width constant.
REQ-035 One sub-module, sat_add32, SHALL implement the 32+32 signed add with SAT-selectable clamp.
REQ-036 The decode-side weight mux and this block SHALL share the same package constants.

Verification
REQ-037 Reset, then node 3 terms {5,-2,in_last} -> done 2 cycles after first accept; z_out[3]=1, o_out[3]=0; all other bits 0.
REQ-038 Node 1 terms {-7,3,in_last} then node 1 terms {4,-4,in_last} -> after first: (z,o)[1]=(0,1); after second (sum 0): (z,o)[1] still (0,1).
REQ-039 SAT=1, node 0 terms {0x7FFFFFFF,1,in_last} -> acc clamps to 0x7FFFFFFF; (z,o)[0]=(1,0). SAT=0, same terms -> wraps to 0x80000000; (z,o)[0]=(0,1).
REQ-040 OUTPUTS=6, node_idx=7 single term 9 -> done pulses, z_out/o_out unchanged, err=1; clr in IDLE -> err=0 and all states zeroed.
REQ-041 rst asserted after 2 of 3 terms for node 2 -> no done pulse, (z,o)[2]=(0,0), FSM in IDLE, in_ready=1.
REQ-042 Random stall bench: in_valid toggled pseudo-randomly over 100 nodes -> every commit matches the reference model sign rule; in_ready=0 only in ENCODE; (1,1) never observed.

Source files
------------

// File: rtl/spin_encoder_pkg.sv
// Shared constants for the spin encoder and the decode-side weight mux.
// Holds the FSM state type, the 2-bit spin codes and the datapath widths.
package spin_encoder_pkg;

  localparam int TERM_W = 32;
  localparam int ACC_W  = 34;

  localparam logic [1:0] POS  = 2'b10;
  localparam logic [1:0] NEG  = 2'b01;
  localparam logic [1:0] ZERO = 2'b00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    ENCODE = 2'd2
  } state_t;

  function automatic logic [1:0] spin_code(input logic signed [TERM_W-1:0] v);
    if (v > 0)
      return POS;
    else if (v < 0)
      return NEG;
    else
      return ZERO;
  endfunction

endpackage

// File: rtl/sat_add32.sv
// 32+32 signed adder with a wide internal sum; SAT=1 clamps to the 32-bit
// signed range, SAT=0 keeps the low 32 bits (wrap-around).
module sat_add32
  import spin_encoder_pkg::*;
#(
  parameter int SAT = 1
) (
  input  logic signed [TERM_W-1:0] a,
  input  logic signed [TERM_W-1:0] b,
  output logic signed [TERM_W-1:0] sum
);

  localparam logic signed [ACC_W-1:0] MAX_V =
    {{(ACC_W-TERM_W+1){1'b0}}, {(TERM_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V =
    {{(ACC_W-TERM_W+1){1'b1}}, {(TERM_W-1){1'b0}}};

  logic signed [ACC_W-1:0] wide;

  always_comb begin
    wide = {{(ACC_W-TERM_W){a[TERM_W-1]}}, a} + {{(ACC_W-TERM_W){b[TERM_W-1]}}, b};
    sum  = wide[TERM_W-1:0];
    if (SAT != 0) begin
      if (wide > MAX_V)
        sum = MAX_V[TERM_W-1:0];
      else if (wide < MIN_V)
        sum = MIN_V[TERM_W-1:0];
    end
  end

endmodule

// File: rtl/spin_encoder.sv
// Accumulates a stream of signed terms per node and commits the sign of the
// sum as a (z,o) spin code into the addressed node.
module spin_encoder
  import spin_encoder_pkg::*;
#(
  parameter int  OUTPUTS = 8,
  parameter int  SAT     = 1,
  localparam int IW      = $clog2(OUTPUTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [TERM_W-1:0] in_data,
  input  logic                     in_last,
  input  logic [IW-1:0]            node_idx,
  input  logic                     clr,
  output logic [OUTPUTS-1:0]       z_out,
  output logic [OUTPUTS-1:0]       o_out,
  output logic                     done,
  output logic                     err
);

  state_t                   state, state_nxt;
  logic signed [TERM_W-1:0] acc, acc_sum;
  logic [IW-1:0]            idx_q;
  logic                     accept;
  logic                     idx_ok;
  logic [1:0]               code;

  assign accept = in_valid && in_ready;
  assign idx_ok = int'(idx_q) < OUTPUTS;
  assign code   = spin_code(acc);

  sat_add32 #(.SAT(SAT)) u_add (
    .a   (acc),
    .b   (in_data),
    .sum (acc_sum)
  );

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    case (state)
      IDLE, ACCUM: begin
        if (accept)
          state_nxt = in_last ? ENCODE : ACCUM;
      end
      ENCODE: begin
        in_ready  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // clr is applied before the term so a coincident first term still lands
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      idx_q <= '0;
      z_out <= '0;
      o_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && clr) begin
        z_out <= '0;
        o_out <= '0;
        err   <= 1'b0;
      end
      if (accept) begin
        if (state == IDLE) begin
          acc   <= in_data;
          idx_q <= node_idx;
        end else begin
          acc <= acc_sum;
        end
      end
      if (state == ENCODE) begin
        done <= 1'b1;
        if (!idx_ok)
          err <= 1'b1;
        else if (code != ZERO) begin
          z_out[idx_q] <= code[1];
          o_out[idx_q] <= code[0];
        end
      end
    end
  end

endmodule

// File: tb/tb_spin_encoder.sv
// Directed vector table plus corner sequences and a stalled random run
// against a sign-rule reference model for spin_encoder.
module tb_spin_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, clr;
  logic [31:0] in_data;
  logic [2:0]  node_idx;
  logic [1:0]  sel;

  logic       rdy_a, rdy_b, rdy_c, done_a, done_b, done_c, err_a, err_b, err_c;
  logic [7:0] za, oa, zb, ob;
  logic [5:0] zc, oc;

  logic [7:0] z_s, o_s;
  logic       rdy_s, done_s, err_s;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0]       sel;
    logic [2:0]       idx;
    logic [1:0]       n;
    logic [2:0][31:0] t;
    logic [7:0]       ez;
    logic [7:0]       eo;
    logic             eerr;
  } vec_t;

  vec_t vecs [11];

  always #5 clk = ~clk;

  spin_encoder #(.OUTPUTS(8), .SAT(1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd0), .in_ready(rdy_a),
    .in_data(in_data), .in_last(in_last), .node_idx(node_idx),
    .clr(clr && sel == 2'd0), .z_out(za), .o_out(oa), .done(done_a), .err(err_a));

  spin_encoder #(.OUTPUTS(8), .SAT(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd1), .in_ready(rdy_b),
    .in_data(in_data), .in_last(in_last), .node_idx(node_idx),
    .clr(clr && sel == 2'd1), .z_out(zb), .o_out(ob), .done(done_b), .err(err_b));

  spin_encoder #(.OUTPUTS(6), .SAT(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid && sel == 2'd2), .in_ready(rdy_c),
    .in_data(in_data), .in_last(in_last), .node_idx(node_idx),
    .clr(clr && sel == 2'd2), .z_out(zc), .o_out(oc), .done(done_c), .err(err_c));

  always_comb begin
    z_s = za; o_s = oa; rdy_s = rdy_a; done_s = done_a; err_s = err_a;
    case (sel)
      2'd1: begin z_s = zb; o_s = ob; rdy_s = rdy_b; done_s = done_b; err_s = err_b; end
      2'd2: begin
        z_s = {2'b00, zc}; o_s = {2'b00, oc}; rdy_s = rdy_c; done_s = done_c; err_s = err_c;
      end
      default: ;
    endcase
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] s, input logic [2:0] idx, input logic [1:0] n,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [7:0] ez, input logic [7:0] eo, input logic eerr);
    vec_t v;
    v.sel = s; v.idx = idx; v.n = n;
    v.t[0] = a; v.t[1] = b; v.t[2] = c;
    v.ez = ez; v.eo = eo; v.eerr = eerr;
    return v;
  endfunction

  function automatic longint clamp(input longint v);
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
  endfunction

  task automatic run_node(input string nm, input logic [1:0] s, input logic [2:0] idx,
                          input int n, input logic [2:0][31:0] t,
                          input logic [7:0] ez, input logic [7:0] eo, input logic eerr);
    int lat;
    sel = s;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({nm, " rdy_accept"}, 64'(rdy_s), 64'd1);
      in_valid = 1'b1; in_data = t[i]; in_last = (i == n - 1); node_idx = idx;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    chk({nm, " rdy_encode"}, 64'(rdy_s), 64'd0);
    chk({nm, " done_early"}, 64'(done_s), 64'd0);
    lat = 0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (done_s) lat = c;
    end
    chk({nm, " latency"}, 64'(lat), 64'd1);
    chk({nm, " z"}, 64'(z_s), 64'(ez));
    chk({nm, " o"}, 64'(o_s), 64'(eo));
    chk({nm, " err"}, 64'(err_s), 64'(eerr));
    @(negedge clk);
    chk({nm, " done_pulse"}, 64'(done_s), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint     m;
    logic [7:0] mz, mo;
    logic [2:0] ridx;
    logic [31:0] d;
    int         n;

    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; clr = 1'b0;
    in_data = '0; node_idx = '0; sel = 2'd0;

    vecs[0]  = mk(2'd0, 3'd3, 2'd2, 32'd5,        32'hFFFFFFFE, 32'd0,        8'h08, 8'h00, 1'b0);
    vecs[1]  = mk(2'd0, 3'd1, 2'd2, 32'hFFFFFFF9, 32'd3,        32'd0,        8'h08, 8'h02, 1'b0);
    vecs[2]  = mk(2'd0, 3'd1, 2'd2, 32'd4,        32'hFFFFFFFC, 32'd0,        8'h08, 8'h02, 1'b0);
    vecs[3]  = mk(2'd0, 3'd0, 2'd2, 32'h7FFFFFFF, 32'd1,        32'd0,        8'h09, 8'h02, 1'b0);
    vecs[4]  = mk(2'd0, 3'd3, 2'd1, 32'hFFFFFFFF, 32'd0,        32'd0,        8'h01, 8'h0A, 1'b0);
    vecs[5]  = mk(2'd0, 3'd7, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        8'h01, 8'h8A, 1'b0);
    vecs[6]  = mk(2'd1, 3'd0, 2'd2, 32'h7FFFFFFF, 32'd1,        32'd0,        8'h00, 8'h01, 1'b0);
    vecs[7]  = mk(2'd1, 3'd5, 2'd2, 32'h80000000, 32'hFFFFFFFF, 32'd0,        8'h20, 8'h01, 1'b0);
    vecs[8]  = mk(2'd1, 3'd2, 2'd3, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFF, 8'h24, 8'h01, 1'b0);
    vecs[9]  = mk(2'd2, 3'd7, 2'd1, 32'd9,        32'd0,        32'd0,        8'h00, 8'h00, 1'b1);
    vecs[10] = mk(2'd2, 3'd5, 2'd1, 32'hFFFFFFFE, 32'd0,        32'd0,        8'h00, 8'h20, 1'b1);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset rdy_a", 64'(rdy_a), 64'd1);
    chk("reset rdy_c", 64'(rdy_c), 64'd1);
    chk("reset z_a", 64'(za), 64'd0);
    chk("reset o_a", 64'(oa), 64'd0);
    chk("reset done_a", 64'(done_a), 64'd0);
    chk("reset err_c", 64'(err_c), 64'd0);

    for (int v = 0; v < 11; v++)
      run_node($sformatf("vec%0d", v), vecs[v].sel, vecs[v].idx, int'(vecs[v].n), vecs[v].t,
               vecs[v].ez, vecs[v].eo, vecs[v].eerr);

    // clr in IDLE on the OUTPUTS=6 instance drops err and node states
    sel = 2'd2;
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    @(negedge clk);
    chk("clr_idle z", 64'(z_s), 64'd0);
    chk("clr_idle o", 64'(o_s), 64'd0);
    chk("clr_idle err", 64'(err_s), 64'd0);

    // clr held while stalled in ACCUM is ignored
    sel = 2'd0;
    @(negedge clk); in_valid = 1'b1; in_data = 32'd10; in_last = 1'b0; node_idx = 3'd6;
    @(negedge clk); in_valid = 1'b0; clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall rdy", 64'(rdy_s), 64'd1);
    end
    clr = 1'b0; in_valid = 1'b1; in_data = 32'hFFFFFFFD; in_last = 1'b1;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("clr_accum done", 64'(done_s), 64'd1);
    chk("clr_accum z", 64'(z_s), 64'h41);
    chk("clr_accum o", 64'(o_s), 64'h8A);

    // clr coincident with a first term: clear, then the node commits
    @(negedge clk); clr = 1'b1; in_valid = 1'b1; in_data = 32'hFFFFFFFC; in_last = 1'b1; node_idx = 3'd2;
    @(negedge clk); clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("clr_term done", 64'(done_s), 64'd1);
    chk("clr_term z", 64'(z_s), 64'h00);
    chk("clr_term o", 64'(o_s), 64'h04);

    // reset after two of three terms abandons the partial sum
    @(negedge clk); in_valid = 1'b1; in_data = 32'd6; in_last = 1'b0; node_idx = 3'd2;
    @(negedge clk); in_data = 32'hFFFFFFFF;
    @(negedge clk); in_valid = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_accum done", 64'(done_s), 64'd0);
    chk("rst_accum rdy", 64'(rdy_s), 64'd1);
    chk("rst_accum z", 64'(z_s), 64'd0);
    chk("rst_accum o", 64'(o_s), 64'd0);
    run_node("after_rst", 2'd0, 3'd2, 1, {32'd0, 32'd0, 32'hFFFFFFFB}, 8'h00, 8'h04, 1'b0);

    // reset during ENCODE suppresses the commit and the done pulse
    @(negedge clk); in_valid = 1'b1; in_data = 32'd8; in_last = 1'b1; node_idx = 3'd4;
    @(negedge clk); in_valid = 1'b0; in_last = 1'b0; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_encode done", 64'(done_s), 64'd0);
    chk("rst_encode z", 64'(z_s), 64'd0);
    chk("rst_encode o", 64'(o_s), 64'd0);
    @(negedge clk);
    chk("rst_encode done_after", 64'(done_s), 64'd0);
    chk("rst_encode rdy", 64'(rdy_s), 64'd1);

    // stalled random nodes against the saturating sign model
    mz = '0; mo = '0; m = 0;
    for (int k = 0; k < 100; k++) begin
      ridx = 3'($urandom_range(0, 7));
      n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk); in_valid = 1'b0;
          chk("rand stall rdy", 64'(rdy_s), 64'd1);
        end
        case ($urandom_range(0, 5))
          0: d = 32'h7FFFFFFF;
          1: d = 32'h80000000;
          default: d = 32'($signed(int'($urandom_range(0, 40)) - 20));
        endcase
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = (i == n - 1); node_idx = ridx;
        if (i == 0) m = longint'($signed(d));
        else m = clamp(m + longint'($signed(d)));
      end
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      chk("rand rdy_encode", 64'(rdy_s), 64'd0);
      chk("rand done_early", 64'(done_s), 64'd0);
      if (m > 0) begin mz[ridx] = 1'b1; mo[ridx] = 1'b0; end
      else if (m < 0) begin mz[ridx] = 1'b0; mo[ridx] = 1'b1; end
      @(negedge clk);
      chk("rand done", 64'(done_s), 64'd1);
      chk("rand z", 64'(z_s), 64'(mz));
      chk("rand o", 64'(o_s), 64'(mo));
      chk("rand no_11", 64'(z_s & o_s), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
